icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/aww_types_pkg.sv | 17 +
 rtl/cpu_types_pkg.sv | 8 +
 rtl/icache_array.sv | 57 +++++
 rtl/icache.sv | 129 ++++++++++++
 4 files changed

// File: rtl/aww_types_pkg.sv
// Instruction cache types: controller states and fetch-address field layout (default 16-set geometry).
package aww_types_pkg;

  localparam int ICACHE_IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic [29-ICACHE_IDX_W:0] tag;
    logic [ICACHE_IDX_W-1:0]  idx;
    logic [1:0]               bytoff;
  } icache_addr_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/data storage, one word per set; invalidate-all overrides a same-cycle write.
module icache_array
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inv,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  word_t            data_q [SETS];
  word_t            data_d [SETS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    if (inv) begin
      valid_d = '0;
    end
  end

  // Only the valid bits need reset; stale tag/data is masked by valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-set instruction cache with a blocking IDLE/FETCH miss handler.
// Define ICACHE_STATS_EN to add the hit_count / miss_count outputs.
module icache
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dpif_imemREN,
  input  logic [31:0] dpif_imemaddr,
  output logic        dpif_ihit,
  output logic [31:0] dpif_imemload,
  input  logic        icache_inv,
  output logic        ccif_iREN,
  output logic [31:0] ccif_iaddr,
  input  logic        ccif_iwait,
  input  logic [31:0] ccif_iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state_q, state_d;
  word_t            addr_q, addr_d;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  word_t            rd_data;
  logic             hit;
  logic             fill_done;
  logic [1:0]       unused_bytoff;

  assign req_idx       = dpif_imemaddr[IDX_W+1:2];
  assign req_tag       = dpif_imemaddr[31:IDX_W+2];
  assign unused_bytoff = dpif_imemaddr[1:0];

  icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .CLK      (CLK),
    .RST      (RST),
    .inv      (icache_inv),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_done && !RST),
    .wr_idx   (addr_q[IDX_W+1:2]),
    .wr_tag   (addr_q[31:IDX_W+2]),
    .wr_data  (ccif_iload)
  );

  assign hit           = (state_q == IDLE) && dpif_imemREN && rd_valid && (rd_tag == req_tag);
  assign dpif_ihit     = hit;
  assign dpif_imemload = hit ? rd_data : '0;

  // The fill target is the latched address, so datapath changes during FETCH are ignored.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ccif_iREN  = 1'b0;
    ccif_iaddr = '0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dpif_imemREN && !hit) begin
          addr_d  = dpif_imemaddr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ccif_iREN  = 1'b1;
        ccif_iaddr = addr_q;
        if (!ccif_iwait) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        miss_start;

  assign miss_start = (state_q == IDLE) && dpif_imemREN && !hit;

  always_comb begin
    hit_count_d  = hit_count_q + (hit ? 32'd1 : 32'd0);
    miss_count_d = miss_count_q + (miss_start ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
